// File: rtl/slice_sequencer.sv
// slice_sequencer: round-robin sharing of one SW-bit slice unit between two
// requesters. The winner's operand pair is captured and sent through the
// slice unit one slice per cycle. The assembled result comes back on C with a
// one-cycle VLD pulse, and VID names the requester that owns it.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation in flight; arbitrate on every edge
// RUN   | slice K of the captured operands is on SA/SB, SC is collected
// DONE  | C/VID were just loaded, VLD high; arbitrate again (no bubble)
module slice_sequencer #(
   parameter int SW     = 41,
   parameter int NSLICE = 3
) (
   input  logic                   CK,
   input  logic                   RN,
   input  logic                   REQ0,
   input  logic                   REQ1,
   input  logic [SW*NSLICE-1:0]   A0,
   input  logic [SW*NSLICE-1:0]   B0,
   input  logic [SW*NSLICE-1:0]   A1,
   input  logic [SW*NSLICE-1:0]   B1,
   output logic                   GNT0,
   output logic                   GNT1,
   output logic [SW-1:0]          SA,
   output logic [SW-1:0]          SB,
   input  logic [SW-1:0]          SC,
   output logic [SW*NSLICE-1:0]   C,
   output logic                   VLD,
   output logic                   VID
);

   localparam int W  = SW * NSLICE;
   localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic            last_q, last_d;
   logic            own_q, own_d;
   logic [W-1:0]    opa_q, opa_d;
   logic [W-1:0]    opb_q, opb_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [W-1:0]    c_q, c_d;
   logic            vid_q, vid_d;
   logic            gnt0_q, gnt0_d;
   logic            gnt1_q, gnt1_d;
   logic            vld_q, vld_d;

   logic            req_any;
   logic            win;
   int              slice_base;

   // Arbitration: a lone requester wins; on a tie the one not granted last wins.
   always_comb begin
      req_any    = REQ0 | REQ1;
      win        = (REQ0 && REQ1) ? ~last_q : REQ1;
      slice_base = int'(k_q) * SW;
   end

   // Next-state logic: slice stepping, result assembly and operand capture.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      last_d  = last_q;
      own_d   = own_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      acc_d   = acc_q;
      c_d     = c_q;
      vid_d   = vid_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      vld_d   = 1'b0;

      case (state_q)
         ST_RUN: begin
            acc_d[slice_base +: SW] = SC;
            if (k_q == K_LAST) begin
               // acc_d already holds the lower slices plus SC in the top slice
               c_d     = acc_d;
               vid_d   = own_q;
               vld_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         ST_IDLE, ST_DONE: begin
            if (req_any) begin
               opa_d   = win ? A1 : A0;
               opb_d   = win ? B1 : B0;
               own_d   = win;
               last_d  = win;
               k_d     = '0;
               gnt0_d  = ~win;
               gnt1_d  = win;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            k_d     = '0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge CK) begin
      if (!RN) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         last_q  <= 1'b1;
         own_q   <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         c_q     <= '0;
         vid_q   <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         last_q  <= last_d;
         own_q   <= own_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         vid_q   <= vid_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         vld_q   <= vld_d;
      end
   end

   // Slice operands go to the shared unit only while running; zero otherwise.
   always_comb begin
      SA = '0;
      SB = '0;
      if (state_q == ST_RUN) begin
         SA = opa_q[slice_base +: SW];
         SB = opb_q[slice_base +: SW];
      end
   end

   assign GNT0 = gnt0_q;
   assign GNT1 = gnt1_q;
   assign C    = c_q;
   assign VLD  = vld_q;
   assign VID  = vid_q;

endmodule

// File: tb/tb_slice_sequencer.sv
// Bench for slice_sequencer. The slice unit is modelled as SC = SA ^ SB. The
// reference model works per operation: it captures the winning operand words,
// counts cycles since the grant, and produces the whole-word result A ^ B.
module tb_slice_sequencer;

   localparam int SW     = 41;
   localparam int NSLICE = 3;
   localparam int W      = SW * NSLICE;

   logic          CK;
   logic          RN;
   logic          REQ0, REQ1;
   logic [W-1:0]  A0, B0, A1, B1;
   logic          GNT0, GNT1;
   logic [SW-1:0] SA, SB, SC;
   logic [W-1:0]  C;
   logic          VLD, VID;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // reference model state
   int           m_phase;   // -1: free to arbitrate, 0..NSLICE-1: slice in progress
   logic         m_last, m_own, m_vid;
   logic [W-1:0] m_opa, m_opb, m_c;
   logic         m_gnt0, m_gnt1, m_vld;

   slice_sequencer #(.SW(SW), .NSLICE(NSLICE)) dut (
      .CK(CK), .RN(RN), .REQ0(REQ0), .REQ1(REQ1),
      .A0(A0), .B0(B0), .A1(A1), .B1(B1),
      .GNT0(GNT0), .GNT1(GNT1), .SA(SA), .SB(SB), .SC(SC),
      .C(C), .VLD(VLD), .VID(VID)
   );

   assign SC = SA ^ SB;

   initial CK = 1'b0;
   always #5 CK = ~CK;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] rand_w();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[W-1:0];
   endfunction

   function automatic logic [SW-1:0] exp_slice(input logic [W-1:0] word);
      logic [W-1:0] t;
      if (m_phase < 0) return '0;
      t = word >> (m_phase * SW);
      return t[SW-1:0];
   endfunction

   // Reference model: advance by one edge using the inputs about to be sampled.
   task automatic model_edge();
      logic w;
      m_gnt0 = 1'b0;
      m_gnt1 = 1'b0;
      m_vld  = 1'b0;
      if (!RN) begin
         m_phase = -1; m_last = 1'b1; m_own = 1'b0;
         m_opa = '0; m_opb = '0; m_c = '0; m_vid = 1'b0;
      end else if (m_phase >= 0 && m_phase < NSLICE - 1) begin
         m_phase++;
      end else if (m_phase == NSLICE - 1) begin
         m_c     = m_opa ^ m_opb;
         m_vid   = m_own;
         m_vld   = 1'b1;
         m_phase = -1;
      end else if (REQ0 || REQ1) begin
         w       = (REQ0 && REQ1) ? !m_last : REQ1;
         m_opa   = w ? A1 : A0;
         m_opb   = w ? B1 : B0;
         m_own   = w;
         m_last  = w;
         m_phase = 0;
         m_gnt0  = !w;
         m_gnt1  = w;
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge CK);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      RN = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
      A0 = '0; B0 = '0; A1 = '0; B1 = '0;
      cycle();
      cycle();
      n_chk++; if (GNT0 !== 1'b0 || GNT1 !== 1'b0) begin n_err++; $display("FAIL reset_gnt got=%b%b exp=00", GNT0, GNT1); end
      n_chk++; if (VLD !== 1'b0 || VID !== 1'b0) begin n_err++; $display("FAIL reset_vld got vld=%b vid=%b exp=0 0", VLD, VID); end
      n_chk++; if (C !== '0) begin n_err++; $display("FAIL reset_c got=%h exp=0", C); end
      n_chk++; if (SA !== '0 || SB !== '0) begin n_err++; $display("FAIL reset_sab got=%h/%h exp=0/0", SA, SB); end
      RN = 1'b1;
      cycle();
      n_chk++; if (GNT0 !== 1'b0 || GNT1 !== 1'b0 || VLD !== 1'b0) begin n_err++; $display("FAIL reset_idle got gnt=%b%b vld=%b exp=000", GNT0, GNT1, VLD); end
   endtask

   task automatic test_single_req0();
      logic [W-1:0] av;
      av = 123'h2_00000002_00000001;
      A0 = av; B0 = '0; REQ0 = 1'b1;
      cycle();
      REQ0 = 1'b0;
      n_chk++; if (GNT0 !== 1'b1 || GNT1 !== 1'b0) begin n_err++; $display("FAIL single_gnt got=%b%b exp=10", GNT0, GNT1); end
      n_chk++; if (SA !== av[SW-1:0] || SB !== '0) begin n_err++; $display("FAIL single_slice0 got=%h/%h exp=%h/0", SA, SB, av[SW-1:0]); end
      cycle();
      n_chk++; if (SA !== av[2*SW-1:SW] || VLD !== 1'b0) begin n_err++; $display("FAIL single_slice1 got sa=%h vld=%b exp sa=%h vld=0", SA, VLD, av[2*SW-1:SW]); end
      cycle();
      n_chk++; if (SA !== av[3*SW-1:2*SW] || VLD !== 1'b0) begin n_err++; $display("FAIL single_slice2 got sa=%h vld=%b exp sa=%h vld=0", SA, VLD, av[3*SW-1:2*SW]); end
      cycle();
      n_chk++; if (VLD !== 1'b1) begin n_err++; $display("FAIL single_vld got=%b exp=1", VLD); end
      n_chk++; if (C !== av || VID !== 1'b0) begin n_err++; $display("FAIL single_c got c=%h vid=%b exp c=%h vid=0", C, VID, av); end
      n_chk++; if (SA !== '0 || GNT0 !== 1'b0) begin n_err++; $display("FAIL single_done got sa=%h gnt0=%b exp 0 0", SA, GNT0); end
      cycle();
      n_chk++; if (VLD !== 1'b0 || C !== av) begin n_err++; $display("FAIL single_after got vld=%b c=%h exp vld=0 c=%h", VLD, C, av); end
   endtask

   task automatic test_tie();
      int g_idx[$];
      int g_cyc[$];
      int exp_order[3];
      logic [W-1:0] ones_b0;
      exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0;
      ones_b0 = '1;
      ones_b0[0] = 1'b0;
      RN = 1'b0;
      cycle();
      RN = 1'b1;
      A0 = rand_w(); B0 = rand_w(); A1 = '1; B1 = 123'h1;
      REQ0 = 1'b1; REQ1 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (GNT0) begin g_idx.push_back(0); g_cyc.push_back(cyc); end
         if (GNT1) begin g_idx.push_back(1); g_cyc.push_back(cyc); end
         n_chk++; if (GNT0 !== m_gnt0 || GNT1 !== m_gnt1) begin n_err++; $display("FAIL tie_gnt cyc=%0d got=%b%b exp=%b%b", cyc, GNT0, GNT1, m_gnt0, m_gnt1); end
         n_chk++; if (VLD !== m_vld || C !== m_c || VID !== m_vid) begin n_err++; $display("FAIL tie_res cyc=%0d got vld=%b vid=%b c=%h exp vld=%b vid=%b c=%h", cyc, VLD, VID, C, m_vld, m_vid, m_c); end
         if (VLD === 1'b1 && VID === 1'b1) begin
            n_chk++; if (C !== ones_b0) begin n_err++; $display("FAIL tie_c1 got=%h exp=%h", C, ones_b0); end
         end
      end
      REQ0 = 1'b0; REQ1 = 1'b0;
      n_chk++;
      if (g_idx.size() != 3) begin
         n_err++; $display("FAIL tie_count got=%0d exp=3", g_idx.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_chk++; if (g_idx[i] != exp_order[i]) begin n_err++; $display("FAIL tie_order idx=%0d got=%0d exp=%0d", i, g_idx[i], exp_order[i]); end
         end
         for (int i = 0; i < 2; i++) begin
            n_chk++; if (g_cyc[i+1] - g_cyc[i] != 4) begin n_err++; $display("FAIL tie_spacing idx=%0d got=%0d exp=4", i, g_cyc[i+1] - g_cyc[i]); end
         end
      end
      cycle();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ka, kb, ja, jb;
      ka = rand_w(); kb = rand_w(); ja = rand_w(); jb = rand_w();
      A0 = ka; B0 = kb; REQ0 = 1'b1;
      cycle();
      n_chk++; if (GNT0 !== 1'b1) begin n_err++; $display("FAIL b2b_gnt0 got=%b exp=1", GNT0); end
      REQ0 = 1'b0; REQ1 = 1'b1; A1 = ja; B1 = jb;
      A0 = rand_w(); B0 = rand_w();
      cycle();
      A0 = rand_w();
      cycle();
      n_chk++; if (GNT1 !== 1'b0 || VLD !== 1'b0) begin n_err++; $display("FAIL b2b_run got gnt1=%b vld=%b exp 0 0", GNT1, VLD); end
      cycle();
      n_chk++; if (VLD !== 1'b1 || GNT1 !== 1'b0) begin n_err++; $display("FAIL b2b_vld got vld=%b gnt1=%b exp 1 0", VLD, GNT1); end
      n_chk++; if (C !== (ka ^ kb) || VID !== 1'b0) begin n_err++; $display("FAIL b2b_c0 got c=%h vid=%b exp c=%h vid=0", C, VID, ka ^ kb); end
      cycle();
      REQ1 = 1'b0;
      n_chk++; if (GNT1 !== 1'b1 || VLD !== 1'b0) begin n_err++; $display("FAIL b2b_gnt1 got gnt1=%b vld=%b exp 1 0", GNT1, VLD); end
      cycle();
      cycle();
      cycle();
      n_chk++; if (VLD !== 1'b1 || C !== (ja ^ jb) || VID !== 1'b1) begin n_err++; $display("FAIL b2b_c1 got vld=%b vid=%b c=%h exp vld=1 vid=1 c=%h", VLD, VID, C, ja ^ jb); end
      cycle();
   endtask

   task automatic test_operand_sampling();
      logic [W-1:0] ka, kb;
      ka = rand_w(); kb = rand_w();
      A0 = ka; B0 = kb; REQ0 = 1'b1;
      cycle();
      REQ0 = 1'b0;
      A0 = ~ka;
      cycle();
      n_chk++; if (SA !== ka[2*SW-1:SW]) begin n_err++; $display("FAIL samp_sa got=%h exp=%h", SA, ka[2*SW-1:SW]); end
      B0 = rand_w();
      cycle();
      cycle();
      n_chk++; if (VLD !== 1'b1 || C !== (ka ^ kb)) begin n_err++; $display("FAIL samp_c got vld=%b c=%h exp vld=1 c=%h", VLD, C, ka ^ kb); end
      cycle();
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] ja, jb;
      int g_at, v_at;
      A0 = rand_w(); B0 = rand_w(); REQ0 = 1'b1;
      cycle();
      REQ0 = 1'b0;
      cycle();
      ja = rand_w(); jb = rand_w();
      RN = 1'b0; REQ1 = 1'b1; A1 = ja; B1 = jb;
      for (int i = 0; i < 2; i++) begin
         cycle();
         n_chk++; if (VLD !== 1'b0 || C !== '0 || SA !== '0 || SB !== '0) begin n_err++; $display("FAIL rmid_clear got vld=%b c=%h sa=%h sb=%h exp all 0", VLD, C, SA, SB); end
      end
      RN = 1'b1;
      g_at = -1; v_at = -1;
      for (int i = 1; i <= 8 && v_at < 0; i++) begin
         cycle();
         if (GNT1 === 1'b1) begin g_at = i; REQ1 = 1'b0; end
         if (VLD === 1'b1) v_at = i;
      end
      n_chk++; if (g_at != 1) begin n_err++; $display("FAIL rmid_gnt1 got cycle=%0d exp=1", g_at); end
      n_chk++;
      if (v_at != 4) begin
         n_err++; $display("FAIL rmid_vld got cycle=%0d exp=4", v_at);
      end else if (C !== (ja ^ jb) || VID !== 1'b1) begin
         n_err++; $display("FAIL rmid_c got c=%h vid=%b exp c=%h vid=1", C, VID, ja ^ jb);
      end
      REQ1 = 1'b0;
      cycle();
   endtask

   task automatic test_idle();
      REQ0 = 1'b0; REQ1 = 1'b0;
      for (int i = 0; i < 4; i++) cycle();
      for (int i = 0; i < 10; i++) begin
         A0 = rand_w(); B1 = rand_w();
         cycle();
         n_chk++; if (SA !== '0 || SB !== '0 || GNT0 !== 1'b0 || GNT1 !== 1'b0 || VLD !== 1'b0) begin n_err++; $display("FAIL idle_out cyc=%0d got sa=%h sb=%h gnt=%b%b vld=%b exp all 0", cyc, SA, SB, GNT0, GNT1, VLD); end
         n_chk++; if (C !== m_c) begin n_err++; $display("FAIL idle_c got=%h exp=%h", C, m_c); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if (!REQ0 && $urandom_range(0, 2) == 0) REQ0 = 1'b1;
         if (!REQ1 && $urandom_range(0, 2) == 0) REQ1 = 1'b1;
         if ($urandom_range(0, 1) == 0) begin A0 = rand_w(); B0 = rand_w(); end
         if ($urandom_range(0, 1) == 0) begin A1 = rand_w(); B1 = rand_w(); end
         RN = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
         cycle();
         n_chk++; if (GNT0 !== m_gnt0 || GNT1 !== m_gnt1) begin n_err++; $display("FAIL rnd_gnt cyc=%0d got=%b%b exp=%b%b", cyc, GNT0, GNT1, m_gnt0, m_gnt1); end
         n_chk++; if (VLD !== m_vld || VID !== m_vid) begin n_err++; $display("FAIL rnd_vld cyc=%0d got vld=%b vid=%b exp vld=%b vid=%b", cyc, VLD, VID, m_vld, m_vid); end
         n_chk++; if (C !== m_c) begin n_err++; $display("FAIL rnd_c cyc=%0d got=%h exp=%h", cyc, C, m_c); end
         n_chk++; if (SA !== exp_slice(m_opa) || SB !== exp_slice(m_opb)) begin n_err++; $display("FAIL rnd_sab cyc=%0d got=%h/%h exp=%h/%h", cyc, SA, SB, exp_slice(m_opa), exp_slice(m_opb)); end
         n_chk++; if ((GNT0 && GNT1) || ((GNT0 || GNT1) && VLD)) begin n_err++; $display("FAIL rnd_excl cyc=%0d got gnt=%b%b vld=%b exp at most one", cyc, GNT0, GNT1, VLD); end
         if (GNT0) REQ0 = 1'b0;
         if (GNT1) REQ1 = 1'b0;
      end
      RN = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
   endtask

   initial begin
      RN = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
      A0 = '0; B0 = '0; A1 = '0; B1 = '0;
      m_phase = -1; m_last = 1'b1; m_own = 1'b0; m_vid = 1'b0;
      m_opa = '0; m_opb = '0; m_c = '0;
      m_gnt0 = 1'b0; m_gnt1 = 1'b0; m_vld = 1'b0;
      test_reset();
      test_single_req0();
      test_tie();
      test_back_to_back();
      test_operand_sampling();
      test_reset_mid();
      test_idle();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/slice_sequencer.md
# slice_sequencer

Time-multiplexed controller that shares one 41-bit slice datapath between two requesters. Each requester presents a 123-bit operand pair (three 41-bit slices, the width of the three-instance slice array in the top-level netlist). The block arbitrates round-robin, captures the winner's operands and drives them through the external slice unit one slice per cycle. It then assembles the 123-bit result and returns it with a one-cycle valid pulse.

## Interface
- `SW`, 41: slice width in bits
- `NSLICE`, 3: slices per operation; `W = SW*NSLICE` (123)
- `CK`  in  1  clock; all state updates on rising edge
- `RN`  in  1  reset, synchronous, active-low
- `REQ0`, `REQ1`  in  1 each  operation request from requester 0 / 1; level, held until own GNT
- `A0`, `B0`, `A1`, `B1`  in  W each  operand pairs; sampled only on the granting edge
- `GNT0`, `GNT1`  out  1 each  one-cycle grant pulse; operands already captured
- `SA`, `SB`  out  SW each  current slice operands to shared slice unit
- `SC`  in  SW  slice unit result; combinational from `SA`/`SB`, sampled same cycle
- `C`  out  W  assembled result; held until next completion
- `VLD`  out  1  one-cycle pulse, `C` valid
- `VID`  out  1  requester index owning `C`

## Operation
- States: `IDLE`, `RUN`, `DONE`. Slice counter `K` (2 bits, range 0..NSLICE-1). Priority flag `LAST` records the last granted index.
- Arbitration happens on any edge while in `IDLE` or `DONE`:
  - Only one REQ high: that requester wins.
  - Both high: the winner is `!LAST`.
  - The winner's `A`/`B` are copied into internal `OPA`/`OPB` (W bits each), `OWN` is set to the winner, `LAST` is set to the winner, `K` is cleared, and the state goes to `RUN`.
  - No REQ from `IDLE`: stay in `IDLE`. No REQ from `DONE`: go to `IDLE`.
- `RUN`:
  - `SA = OPA[K*SW +: SW]`, `SB = OPB[K*SW +: SW]`.
  - Each edge writes `ACC[K*SW +: SW] <= SC`.
  - `K < NSLICE-1`: increment `K`.
  - `K == NSLICE-1`: load `C <= {SC, ACC[(NSLICE-1)*SW-1:0]}` and `VID <= OWN`, then go to `DONE`.
- `DONE`: `VLD = 1` for exactly this cycle; arbitration as above.
- `SA`/`SB` are forced to 0 outside `RUN`.
- `GNTx` is a registered pulse, high in the first `RUN` cycle when `OWN == x`.
- No width extension or truncation: slice k maps exactly to bits `[41k+40:41k]`. `K` never exceeds NSLICE-1.
- Reset (`RN` low at an edge), any state:
  - State goes to `IDLE`, `K = 0`, `LAST = 1` (so requester 0 wins the first tie).
  - `OPA`, `OPB`, `ACC`, `C` = 0. `GNT0`, `GNT1`, `VLD`, `VID` = 0.
  - An operation in flight is aborted and never signals `VLD`. Requests still high after reset are re-arbitrated.
- Requests arriving during `RUN` are ignored until `DONE`; they are not lost while REQ is held.

## Timing
- Edge e0 samples REQ and captures operands.
  - Cycles e0..e1: `GNTx` = 1, slice 0 driven.
  - Cycles e1..e2: slice 1 driven.
  - Cycles e2..e3: slice 2 driven.
  - Cycles e3..e4: `VLD` = 1, `C` valid.
- Latency from the granting edge to `VLD` high: 3 cycles.
- Throughput: one operation per 4 cycles, since `DONE` overlaps with the next grant.
- `C`/`VID` change only on the edge entering `DONE`. They are stable from then until the next such edge.
- Each edge: at most one GNT and one VLD. GNT and VLD are never high in the same cycle.
- The slice unit must settle `SC` within one cycle. The block imposes no multicycle path.

## Test plan
Bench slice model for all scenarios: `SC = SA ^ SB`.
- **Single request, requester 0.** Stimulus: `REQ0` pulse with `A0 = 123'h2_00000002_00000001`, `B0 = 0`. Required: `GNT0` 1 cycle later; `VLD` 3 cycles after the grant cycle starts; `C = A0`; `VID = 0`.
- **Tie after reset.** Stimulus: `REQ0` and `REQ1` both held, with `A1 = all-ones` and `B1 = 123'h1`. Required: grants alternate 0, 1, 0 every 4 cycles. Each `C` equals `Ax^Bx` of its owner: `VID = 1` gives `C = all-ones except bit 0 = 0`.
- **Back-to-back.** Stimulus: `REQ1` raised during `RUN` of a requester-0 operation. Required: `GNT1` in the cycle right after `DONE`, with no idle cycle. Operands changed during `RUN` must not alter the in-flight `C`.
- **Operand sampling.** Stimulus: change `A0` on the cycle after `GNT0`. Required: the result uses the captured value.
- **Reset mid-operation.** Stimulus: `RN` low at the second `RUN` edge. Required: no `VLD` is produced; `C = 0`, `SA = 0`, `SB = 0`. After release with `REQ1` held, `GNT1` occurs and the full operation completes.
- **Idle behaviour.** Stimulus: no requests for 10 cycles. Required: `SA`, `SB`, `GNT0`, `GNT1`, `VLD` all stay 0, and `C` holds its last value.
